// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and responder state for the memory endpoint.
// Imported by the interface, the address generator and the responder.
package axi4_pkg;
   localparam int DATA_W = 64;
   localparam int ID_W   = 4;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_SLVERR = 2'd2
   } resp_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR_DATA,
      S_WR_RESP
   } state_e;
endpackage

// File: rtl/axi4_mem_responder_if.sv
// AXI4 port bundle between an initiator (master) and the memory
// responder (slave).
interface axi4_mem_responder_if;
   import axi4_pkg::*;

   logic              in_arready;
   logic              in_arvalid;
   logic [ID_W-1:0]   in_arid;
   logic [31:0]       in_araddr;
   logic [7:0]        in_arlen;
   logic [2:0]        in_arsize;
   logic [1:0]        in_arburst;
   logic              in_rready;
   logic              in_rvalid;
   logic [ID_W-1:0]   in_rid;
   logic [DATA_W-1:0] in_rdata;
   logic [1:0]        in_rresp;
   logic              in_rlast;
   logic              in_awready;
   logic              in_awvalid;
   logic [ID_W-1:0]   in_awid;
   logic [31:0]       in_awaddr;
   logic [7:0]        in_awlen;
   logic [2:0]        in_awsize;
   logic [1:0]        in_awburst;
   logic              in_wready;
   logic              in_wvalid;
   logic [DATA_W-1:0] in_wdata;
   logic [STRB_W-1:0] in_wstrb;
   logic              in_wlast;
   logic              in_bready;
   logic              in_bvalid;
   logic [ID_W-1:0]   in_bid;
   logic [1:0]        in_bresp;

   modport master (
      input  in_arready, in_rvalid, in_rid, in_rdata, in_rresp, in_rlast,
      input  in_awready, in_wready, in_bvalid, in_bid, in_bresp,
      output in_arvalid, in_arid, in_araddr, in_arlen, in_arsize,
      output in_arburst, in_rready,
      output in_awvalid, in_awid, in_awaddr, in_awlen, in_awsize,
      output in_awburst, in_wvalid, in_wdata, in_wstrb, in_wlast,
      output in_bready
   );

   modport slave (
      output in_arready, in_rvalid, in_rid, in_rdata, in_rresp, in_rlast,
      output in_awready, in_wready, in_bvalid, in_bid, in_bresp,
      input  in_arvalid, in_arid, in_araddr, in_arlen, in_arsize,
      input  in_arburst, in_rready,
      input  in_awvalid, in_awid, in_awaddr, in_awlen, in_awsize,
      input  in_awburst, in_wvalid, in_wdata, in_wstrb, in_wlast,
      input  in_bready
   );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Per-beat address step for FIXED/INCR/WRAP bursts plus the beat's
// error flag (window range, oversize beat, illegal wrap length).
module axi4_burst_addr_gen
   import axi4_pkg::*;
#(
   parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
   parameter int          MEM_WORDS = 1024
) (
   input  logic [31:0] addr,
   input  logic [7:0]  len,
   input  logic [2:0]  size,
   input  logic [1:0]  burst,
   output logic [31:0] next_addr,
   output logic        err
);
   logic [31:0] step;
   logic [31:0] aligned;
   logic [31:0] incr;
   logic [31:0] wrap_mask;
   logic        range_bad;
   logic        wrap_bad;

   always_comb begin
      step      = 32'd1 << size;
      aligned   = addr & ~(step - 32'd1);
      incr      = aligned + step;
      wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;

      next_addr = addr;
      unique case (1'b1)
         burst == BURST_INCR: next_addr = incr;
         // stay inside the (len+1)<<size block that holds the start
         burst == BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
         default:             next_addr = addr;
      endcase

      range_bad = (addr < MEM_BASE) ||
                  ((addr - MEM_BASE) >= 32'(MEM_WORDS * 8));
      wrap_bad  = (burst == BURST_WRAP) &&
                  !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      err       = range_bad || (size > 3'd3) || wrap_bad;
   end
endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 responder terminating a 64-bit port on an internal word memory;
// one transaction at a time, reads and writes granted round-robin.
module axi4_mem_responder
   import axi4_pkg::*;
#(
   parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
   parameter int          MEM_WORDS = 1024
) (
   input logic                 clock,
   input logic                 reset,
   axi4_mem_responder_if.slave bus
);
   localparam int AW = $clog2(MEM_WORDS);

   state_e            state;
   state_e            state_nx;
   logic              prio_rd;
   logic [31:0]       addr;
   logic [7:0]        len;
   logic [7:0]        beat;
   logic [2:0]        size;
   logic [1:0]        burst;
   logic [ID_W-1:0]   id;
   logic              werr;
   logic              over;
   logic [DATA_W-1:0] mem [MEM_WORDS];

   logic [31:0]       next_addr;
   logic              beat_err;
   logic [AW-1:0]     idx;
   logic              grant_rd;
   logic              grant_wr;
   logic              ar_hs;
   logic              aw_hs;
   logic              r_hs;
   logic              w_hs;
   logic              wr_en;

   axi4_burst_addr_gen #(
      .MEM_BASE  (MEM_BASE),
      .MEM_WORDS (MEM_WORDS)
   ) u_gen (
      .addr      (addr),
      .len       (len),
      .size      (size),
      .burst     (burst),
      .next_addr (next_addr),
      .err       (beat_err)
   );

   always_comb begin
      state_nx       = state;
      bus.in_arready = 1'b0;
      bus.in_awready = 1'b0;
      bus.in_rvalid  = 1'b0;
      bus.in_rid     = '0;
      bus.in_rdata   = '0;
      bus.in_rresp   = RESP_OKAY;
      bus.in_rlast   = 1'b0;
      bus.in_wready  = 1'b0;
      bus.in_bvalid  = 1'b0;
      bus.in_bid     = '0;
      bus.in_bresp   = RESP_OKAY;
      grant_rd = bus.in_arvalid && (prio_rd || !bus.in_awvalid);
      grant_wr = bus.in_awvalid && (!prio_rd || !bus.in_arvalid);
      idx      = AW'((addr - MEM_BASE) >> 3);
      ar_hs    = 1'b0;
      aw_hs    = 1'b0;
      r_hs     = 1'b0;
      w_hs     = 1'b0;

      unique case (state)
         S_IDLE: begin
            bus.in_arready = grant_rd;
            bus.in_awready = grant_wr;
            ar_hs = grant_rd;
            aw_hs = grant_wr;
            if (grant_rd)
               state_nx = S_RD;
            else if (grant_wr)
               state_nx = S_WR_DATA;
         end
         S_RD: begin
            bus.in_rvalid = 1'b1;
            bus.in_rid    = id;
            bus.in_rdata  = beat_err ? '0 : mem[idx];
            bus.in_rresp  = beat_err ? RESP_SLVERR : RESP_OKAY;
            bus.in_rlast  = (beat == len);
            r_hs = bus.in_rready;
            if (r_hs && beat == len)
               state_nx = S_IDLE;
         end
         S_WR_DATA: begin
            bus.in_wready = 1'b1;
            w_hs = bus.in_wvalid;
            if (w_hs && bus.in_wlast)
               state_nx = S_WR_RESP;
         end
         S_WR_RESP: begin
            bus.in_bvalid = 1'b1;
            bus.in_bid    = id;
            bus.in_bresp  = werr ? RESP_SLVERR : RESP_OKAY;
            if (bus.in_bready)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase

      wr_en = w_hs && !over && !beat_err && !reset;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         prio_rd <= 1'b1;
         addr    <= '0;
         len     <= '0;
         beat    <= '0;
         size    <= '0;
         burst   <= '0;
         id      <= '0;
         werr    <= 1'b0;
         over    <= 1'b0;
      end else begin
         state <= state_nx;
         if (ar_hs) begin
            addr    <= bus.in_araddr;
            len     <= bus.in_arlen;
            size    <= bus.in_arsize;
            burst   <= bus.in_arburst;
            id      <= bus.in_arid;
            beat    <= '0;
            werr    <= 1'b0;
            over    <= 1'b0;
            prio_rd <= 1'b0;
         end else if (aw_hs) begin
            addr    <= bus.in_awaddr;
            len     <= bus.in_awlen;
            size    <= bus.in_awsize;
            burst   <= bus.in_awburst;
            id      <= bus.in_awid;
            beat    <= '0;
            werr    <= 1'b0;
            over    <= 1'b0;
            prio_rd <= 1'b1;
         end else if (r_hs && beat != len) begin
            beat <= beat + 8'd1;
            addr <= next_addr;
         end else if (w_hs) begin
            if (beat != len) begin
               beat <= beat + 8'd1;
               addr <= next_addr;
            end else if (!bus.in_wlast) begin
               over <= 1'b1;
            end
            // absorbed beats past len are not range-checked
            if ((beat_err && !over) ||
                (bus.in_wlast && beat != len) ||
                (!bus.in_wlast && beat == len))
               werr <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         for (int i = 0; i < STRB_W; i++)
            if (bus.in_wstrb[i])
               mem[idx][8*i +: 8] <= bus.in_wdata[8*i +: 8];
   end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Self-checking bench for axi4_mem_responder: vector table of bursts,
// R/B scoreboards, plus arbitration, early-wlast and reset sequences.
module tb_axi4_mem_responder;
   import axi4_pkg::*;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          WORDS = 1024;
   localparam logic [31:0] OOB   = BASE + 32'(8 * WORDS);

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   axi4_mem_responder_if bus();

   axi4_mem_responder #(
      .MEM_BASE  (BASE),
      .MEM_WORDS (WORDS)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rexp_t;

   typedef struct {
      logic [1:0] resp;
      logic [3:0] id;
   } bexp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [7:0]  strb;
      logic [63:0] seed;
      logic [1:0]  bresp;
   } vec_t;

   int    vectors = 0;
   int    miscompares = 0;
   rexp_t rq[$];
   bexp_t bq[$];
   logic [63:0] model [WORDS];
   vec_t  tbl[$];

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic beat_bad(input logic [31:0] a, input logic [7:0] l,
                                     input logic [2:0] s, input logic [1:0] b);
      return (a < BASE) || (a >= OOB) || (s > 3'd3) ||
             (b == 2'd2 && !(l == 1 || l == 3 || l == 7 || l == 15));
   endfunction

   function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] l,
                                             input logic [2:0] s, input logic [1:0] b,
                                             input int i);
      logic [31:0] st, al, wb, lo;
      st = 32'd1 << s;
      al = a & ~(st - 32'd1);
      wb = (32'(l) + 32'd1) * st;
      lo = a & ~(wb - 32'd1);
      if (i == 0 || b == 2'd0) return a;
      if (b == 2'd1) return al + 32'(i) * st;
      return lo + ((al - lo + 32'(i) * st) % wb);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 3);
   endfunction

   always @(negedge clock) begin
      rexp_t re;
      bexp_t be;
      if (bus.in_rvalid && bus.in_rready) begin
         if (rq.size() == 0) begin
            check("r_unexpected", 64'd1, 64'd0);
         end else begin
            re = rq.pop_front();
            check("rdata", bus.in_rdata, re.data);
            check("rresp", 64'(bus.in_rresp), 64'(re.resp));
            check("rlast", 64'(bus.in_rlast), 64'(re.last));
            check("rid", 64'(bus.in_rid), 64'(re.id));
         end
      end
      if (bus.in_bvalid && bus.in_bready) begin
         if (bq.size() == 0) begin
            check("b_unexpected", 64'd1, 64'd0);
         end else begin
            be = bq.pop_front();
            check("bresp", 64'(bus.in_bresp), 64'(be.resp));
            check("bid", 64'(bus.in_bid), 64'(be.id));
         end
      end
   end

   task automatic drain();
      int n = 0;
      while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      if (rq.size() != 0 || bq.size() != 0) begin
         check("drain_timeout", 64'(rq.size() + bq.size()), 64'd0);
         rq.delete();
         bq.delete();
      end
   endtask

   task automatic ar_send(input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b,
                          input logic [3:0] id);
      int n = 0;
      bus.in_araddr = a; bus.in_arlen = l; bus.in_arsize = s;
      bus.in_arburst = b; bus.in_arid = id; bus.in_arvalid = 1'b1;
      #1;
      while (!bus.in_arready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!bus.in_arready) check("ar_timeout", 64'd0, 64'd1);
      @(posedge clock); #1;
      bus.in_arvalid = 1'b0;
   endtask

   task automatic aw_send(input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b,
                          input logic [3:0] id);
      int n = 0;
      bus.in_awaddr = a; bus.in_awlen = l; bus.in_awsize = s;
      bus.in_awburst = b; bus.in_awid = id; bus.in_awvalid = 1'b1;
      #1;
      while (!bus.in_awready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!bus.in_awready) check("aw_timeout", 64'd0, 64'd1);
      @(posedge clock); #1;
      bus.in_awvalid = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                     input logic [1:0] b, input logic [3:0] id);
      rexp_t e;
      logic [31:0] ad;
      for (int i = 0; i <= int'(l); i++) begin
         ad = beat_addr(a, l, s, b, i);
         e.id = id;
         e.last = (i == int'(l));
         if (beat_bad(ad, l, s, b)) begin
            e.resp = 2'd2; e.data = '0;
         end else begin
            e.resp = 2'd0; e.data = model[widx(ad)];
         end
         rq.push_back(e);
      end
      ar_send(a, l, s, b, id);
      drain();
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                     input logic [1:0] b, input logic [3:0] id, input logic [7:0] strb,
                     input logic [63:0] seed, input int nb, input logic [1:0] exp);
      logic [31:0] ad;
      int n;
      bq.push_back('{exp, id});
      aw_send(a, l, s, b, id);
      for (int i = 0; i < nb; i++) begin
         bus.in_wvalid = 1'b1;
         bus.in_wdata  = seed * 64'(i + 1);
         bus.in_wstrb  = strb;
         bus.in_wlast  = (i == nb - 1);
         ad = beat_addr(a, l, s, b, i);
         if (i <= int'(l) && !beat_bad(ad, l, s, b))
            for (int k = 0; k < 8; k++)
               if (strb[k]) model[widx(ad)][8*k +: 8] = bus.in_wdata[8*k +: 8];
         n = 0;
         #1;
         while (!bus.in_wready && n < 50) begin
            @(posedge clock); #1;
            n++;
         end
         if (!bus.in_wready) check("w_timeout", 64'd0, 64'd1);
         @(posedge clock); #1;
      end
      bus.in_wvalid = 1'b0;
      bus.in_wlast  = 1'b0;
      drain();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_arvalid = 0; bus.in_arid = 0; bus.in_araddr = 0; bus.in_arlen = 0;
      bus.in_arsize = 0; bus.in_arburst = 0; bus.in_rready = 1;
      bus.in_awvalid = 0; bus.in_awid = 0; bus.in_awaddr = 0; bus.in_awlen = 0;
      bus.in_awsize = 0; bus.in_awburst = 0; bus.in_wvalid = 0; bus.in_wdata = 0;
      bus.in_wstrb = 0; bus.in_wlast = 0; bus.in_bready = 1;

      repeat (3) @(posedge clock);
      #1;
      check("rst_arready", 64'(bus.in_arready), 64'd0);
      check("rst_awready", 64'(bus.in_awready), 64'd0);
      check("rst_wready", 64'(bus.in_wready), 64'd0);
      check("rst_rvalid", 64'(bus.in_rvalid), 64'd0);
      check("rst_bvalid", 64'(bus.in_bvalid), 64'd0);
      check("rst_rdata", bus.in_rdata, 64'd0);
      check("rst_rid", 64'(bus.in_rid), 64'd0);
      check("rst_rresp", 64'(bus.in_rresp), 64'd0);
      check("rst_rlast", 64'(bus.in_rlast), 64'd0);
      check("rst_bid", 64'(bus.in_bid), 64'd0);
      check("rst_bresp", 64'(bus.in_bresp), 64'd0);
      reset = 1'b0;

      // simultaneous AR/AW right after reset: read wins, then write wins
      @(posedge clock); #1;
      bus.in_araddr = OOB; bus.in_arlen = 0; bus.in_arsize = 3;
      bus.in_arburst = 1; bus.in_arid = 3;
      bus.in_awaddr = OOB; bus.in_awlen = 0; bus.in_awsize = 3;
      bus.in_awburst = 1; bus.in_awid = 5;
      bus.in_arvalid = 1; bus.in_awvalid = 1;
      #1;
      check("arb1_arready", 64'(bus.in_arready), 64'd1);
      check("arb1_awready", 64'(bus.in_awready), 64'd0);
      rq.push_back('{64'd0, 2'd2, 1'b1, 4'd3});
      @(posedge clock); #1;
      bus.in_arvalid = 0; bus.in_awvalid = 0;
      drain();
      bus.in_arvalid = 1; bus.in_awvalid = 1;
      #1;
      check("arb2_arready", 64'(bus.in_arready), 64'd0);
      check("arb2_awready", 64'(bus.in_awready), 64'd1);
      bq.push_back('{2'd2, 4'd5});
      @(posedge clock); #1;
      bus.in_arvalid = 0; bus.in_awvalid = 0;
      bus.in_wvalid = 1; bus.in_wdata = 64'hDEAD; bus.in_wstrb = 8'hFF; bus.in_wlast = 1;
      #1;
      check("arb2_wready", 64'(bus.in_wready), 64'd1);
      @(posedge clock); #1;
      bus.in_wvalid = 0; bus.in_wlast = 0;
      drain();

      //            wr  addr          len size burst strb   seed                   bresp
      tbl.push_back('{1, BASE,         3, 3, 1, 8'hFF, 64'h11,                2'd0});
      tbl.push_back('{0, BASE,         3, 3, 1, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{0, BASE+32'h10,  3, 3, 2, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{1, BASE+32'h20,  0, 3, 1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0});
      tbl.push_back('{1, BASE+32'h20,  0, 3, 1, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 2'd0});
      tbl.push_back('{0, BASE+32'h20,  0, 3, 1, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{1, BASE+32'h40,  3, 2, 1, 8'hFF, 64'h1000,              2'd0});
      tbl.push_back('{0, BASE+32'h40,  3, 2, 1, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{1, BASE+32'h60,  2, 3, 0, 8'hFF, 64'h5,                 2'd0});
      tbl.push_back('{0, BASE+32'h60,  1, 3, 0, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{0, BASE,         2, 3, 2, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{0, BASE,         0, 4, 1, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{0, OOB,          0, 3, 1, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{1, OOB,          0, 3, 1, 8'hFF, 64'h5555,              2'd2});
      tbl.push_back('{1, OOB-32'h8,    1, 3, 1, 8'hFF, 64'h77,                2'd2});
      tbl.push_back('{0, OOB-32'h8,    1, 3, 1, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{0, BASE,         0, 3, 1, 8'h00, 64'h0,                 2'd0});
      tbl.push_back('{0, BASE+32'h8,   7, 3, 2, 8'h00, 64'h0,                 2'd0});

      foreach (tbl[i]) begin
         if (tbl[i].wr)
            wr(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 4'(i),
               tbl[i].strb, tbl[i].seed, int'(tbl[i].len) + 1, tbl[i].bresp);
         else
            rd(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 4'(i));
      end

      // early wlast ends the burst with SLVERR; beats sent are kept
      wr(BASE+32'h100, 3, 3, 1, 4'd9, 8'hFF, 64'h900, 2, 2'd2);
      rd(BASE+32'h100, 1, 3, 1, 4'd10);

      // R held while rready low, then reset mid-burst
      bus.in_rready = 0;
      ar_send(BASE, 3, 3, 1, 4'd7);
      check("hold_rvalid", 64'(bus.in_rvalid), 64'd1);
      check("hold_rdata0", bus.in_rdata, 64'h11);
      check("hold_rlast0", 64'(bus.in_rlast), 64'd0);
      @(posedge clock); #1;
      check("hold_rdata0b", bus.in_rdata, 64'h11);
      rq.push_back('{64'h11, 2'd0, 1'b0, 4'd7});
      bus.in_rready = 1;
      @(posedge clock); #1;
      bus.in_rready = 0;
      check("hold_rdata1", bus.in_rdata, 64'h22);
      @(posedge clock); #1;
      check("hold_rdata1b", bus.in_rdata, 64'h22);
      check("hold_rvalid1b", 64'(bus.in_rvalid), 64'd1);
      reset = 1;
      @(posedge clock); #1;
      reset = 0;
      check("rst_mid_rvalid", 64'(bus.in_rvalid), 64'd0);
      check("rst_mid_rdata", bus.in_rdata, 64'd0);
      bus.in_rready = 1;
      repeat (5) @(posedge clock);
      #1;
      check("rst_mid_rvalid_late", 64'(bus.in_rvalid), 64'd0);
      check("rst_mid_queue", 64'(rq.size()), 64'd0);
      rd(BASE+32'h10, 0, 3, 1, 4'd11);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
